updown_counter_param: RTL and testbench



---
 rtl/updown_counter_param.sv | 100 ++++++++++
 tb/tb_updown_counter_param.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter.
//
// Counts modulo MAX+1 in either direction, with parallel load (clamped to MAX),
// and either wraps or holds at the limits depending on SATURATE. Flags:
//   tc  - combinational terminal count for the current direction
//   ovf - registered one-cycle pulse when an up-count hits the top limit
//   unf - registered one-cycle pulse when a down-count hits the bottom limit
//
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous active-high reset
//   en    in  1      count enable
//   up    in  1      direction, 1 = increment, 0 = decrement
//   load  in  1      parallel load strobe (beats en)
//   d     in  WIDTH  load value, clamped to MAX
//   c     out WIDTH  current count, always within 0..MAX
//   tc    out 1      terminal count
//   ovf   out 1      overflow / up-saturation pulse
//   unf   out 1      underflow / down-saturation pulse
module updown_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX      = (1 << WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] c,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH:0]   MaxExt = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH-1:0] MaxC   = WIDTH'(MAX);
  localparam logic [WIDTH:0]   OneExt = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // One spare bit keeps the +1 / -1 results from aliasing back into range.
  logic [WIDTH:0] c_ext, d_ext, sum_up, sum_dn;
  logic           unused_carry;

  assign c_ext  = {1'b0, c_q};
  assign d_ext  = {1'b0, d};
  assign sum_up = c_ext + OneExt;
  assign sum_dn = c_ext - OneExt;

  // Counting paths only use these when no carry/borrow can occur.
  assign unused_carry = ^{sum_up[WIDTH], sum_dn[WIDTH]};

  // Next-state for load/count; reset is applied in the register process.
  always_comb begin
    c_d   = c_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (load) begin
      c_d = (d_ext > MaxExt) ? MaxC : d;
    end else if (en) begin
      if (up) begin
        if (c_ext >= MaxExt) begin
          ovf_d = 1'b1;
          c_d   = SATURATE ? MaxC : '0;
        end else begin
          c_d = sum_up[WIDTH-1:0];
        end
      end else begin
        if (c_q == '0) begin
          unf_d = 1'b1;
          c_d   = SATURATE ? '0 : MaxC;
        end else begin
          c_d = sum_dn[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign c   = c_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
  assign tc  = up ? (c_q == MaxC) : (c_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

  logic clk;
  int   n_checks;
  int   n_fail;

  // Config A: WIDTH=2, MAX=3, wrap
  logic       rst_a, en_a, up_a, load_a;
  logic [1:0] d_a, c_a;
  logic       tc_a, ovf_a, unf_a;

  // Config B: WIDTH=3, MAX=5, saturate
  logic       rst_b, en_b, up_b, load_b;
  logic [2:0] d_b, c_b;
  logic       tc_b, ovf_b, unf_b;

  updown_counter_param #(
    .WIDTH   (2),
    .MAX     (3),
    .SATURATE(1'b0)
  ) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .en  (en_a),
    .up  (up_a),
    .load(load_a),
    .d   (d_a),
    .c   (c_a),
    .tc  (tc_a),
    .ovf (ovf_a),
    .unf (unf_a)
  );

  updown_counter_param #(
    .WIDTH   (3),
    .MAX     (5),
    .SATURATE(1'b1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .en  (en_b),
    .up  (up_b),
    .load(load_b),
    .d   (d_b),
    .c   (c_b),
    .tc  (tc_b),
    .ovf (ovf_b),
    .unf (unf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; en_a = 1'b0; up_a = 1'b0; load_a = 1'b0; d_a = '0;
    rst_b = 1'b1; en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; d_b = '0;
    tick();
    tick();
    n_checks++;
    if ({c_a, ovf_a, unf_a} !== 4'b0000) begin
      $display("FAIL reset_a: got c=%0d ovf=%b unf=%b, want c=0 ovf=0 unf=0", c_a, ovf_a, unf_a);
      n_fail++;
    end
    n_checks++;
    if ({c_b, ovf_b, unf_b} !== 5'b00000) begin
      $display("FAIL reset_b: got c=%0d ovf=%b unf=%b, want c=0 ovf=0 unf=0", c_b, ovf_b, unf_b);
      n_fail++;
    end
    n_checks++;
    if (tc_a !== 1'b1) begin
      $display("FAIL reset_tc_down: got tc=%b, want 1", tc_a);
      n_fail++;
    end
    up_a = 1'b1;
    #1;
    n_checks++;
    if (tc_a !== 1'b0) begin
      $display("FAIL reset_tc_up: got tc=%b, want 0", tc_a);
      n_fail++;
    end
    rst_b = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [1:0] exp_c [5];
    logic       exp_ovf [5];
    logic       exp_tc [5];
    exp_c   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rst_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (c_a !== exp_c[i] || ovf_a !== exp_ovf[i] || tc_a !== exp_tc[i] || unf_a !== 1'b0) begin
        $display("FAIL wrap_up[%0d]: got c=%0d ovf=%b tc=%b unf=%b, want c=%0d ovf=%b tc=%b unf=0",
                 i, c_a, ovf_a, tc_a, unf_a, exp_c[i], exp_ovf[i], exp_tc[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [1:0] exp_c [3];
    logic       exp_unf [3];
    logic       exp_tc [3];
    exp_c   = '{2'd0, 2'd3, 2'd2};
    exp_unf = '{1'b0, 1'b1, 1'b0};
    exp_tc  = '{1'b1, 1'b0, 1'b0};
    en_a = 1'b1; up_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (c_a !== exp_c[i] || unf_a !== exp_unf[i] || tc_a !== exp_tc[i] || ovf_a !== 1'b0) begin
        $display("FAIL down_wrap[%0d]: got c=%0d unf=%b tc=%b ovf=%b, want c=%0d unf=%b tc=%b ovf=0",
                 i, c_a, unf_a, tc_a, ovf_a, exp_c[i], exp_unf[i], exp_tc[i]);
        n_fail++;
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    // c_a is 2: one up edge then an immediate direction change.
    en_a = 1'b1; up_a = 1'b1;
    tick();
    n_checks++;
    if (c_a !== 2'd3) begin
      $display("FAIL dir_change_up: got c=%0d, want 3", c_a);
      n_fail++;
    end
    up_a = 1'b0;
    tick();
    n_checks++;
    if (c_a !== 2'd2 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
      $display("FAIL dir_change_down: got c=%0d ovf=%b unf=%b, want c=2 ovf=0 unf=0",
               c_a, ovf_a, unf_a);
      n_fail++;
    end
    en_a = 1'b0;
  endtask

  task automatic test_sat_up();
    logic [2:0] exp_c [3];
    logic       exp_ovf [3];
    exp_c   = '{3'd5, 3'd5, 3'd5};
    exp_ovf = '{1'b0, 1'b1, 1'b1};
    load_b = 1'b1; d_b = 3'd4; en_b = 1'b0;
    tick();
    load_b = 1'b0;
    n_checks++;
    if (c_b !== 3'd4 || ovf_b !== 1'b0) begin
      $display("FAIL sat_load4: got c=%0d ovf=%b, want c=4 ovf=0", c_b, ovf_b);
      n_fail++;
    end
    en_b = 1'b1; up_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (c_b !== exp_c[i] || ovf_b !== exp_ovf[i] || unf_b !== 1'b0 || tc_b !== 1'b1) begin
        $display("FAIL sat_up[%0d]: got c=%0d ovf=%b unf=%b tc=%b, want c=%0d ovf=%b unf=0 tc=1",
                 i, c_b, ovf_b, unf_b, tc_b, exp_c[i], exp_ovf[i]);
        n_fail++;
      end
    end
    en_b = 1'b0;
  endtask

  task automatic test_sat_down_clamp();
    logic [2:0] exp_c [7];
    logic       exp_unf [7];
    exp_c   = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    exp_unf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    load_b = 1'b1; d_b = 3'd7; en_b = 1'b0;
    tick();
    load_b = 1'b0;
    n_checks++;
    if (c_b !== 3'd5 || ovf_b !== 1'b0) begin
      $display("FAIL clamp_load7: got c=%0d ovf=%b, want c=5 ovf=0", c_b, ovf_b);
      n_fail++;
    end
    en_b = 1'b1; up_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (c_b !== exp_c[i] || unf_b !== exp_unf[i] || ovf_b !== 1'b0) begin
        $display("FAIL sat_down[%0d]: got c=%0d unf=%b ovf=%b, want c=%0d unf=%b ovf=0",
                 i, c_b, unf_b, ovf_b, exp_c[i], exp_unf[i]);
        n_fail++;
      end
    end
    n_checks++;
    if (tc_b !== 1'b1) begin
      $display("FAIL sat_down_tc: got tc=%b, want 1", tc_b);
      n_fail++;
    end
    en_b = 1'b0;
  endtask

  task automatic test_priority();
    // c_a is 2 here.
    load_a = 1'b1; d_a = 2'd1; en_a = 1'b1; up_a = 1'b1;
    tick();
    n_checks++;
    if (c_a !== 2'd1 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
      $display("FAIL load_over_en: got c=%0d ovf=%b unf=%b, want c=1 ovf=0 unf=0",
               c_a, ovf_a, unf_a);
      n_fail++;
    end
    // Load from MAX while up-enabled must not raise ovf.
    d_a = 2'd3;
    tick();
    d_a = 2'd3;
    tick();
    n_checks++;
    if (c_a !== 2'd3 || ovf_a !== 1'b0) begin
      $display("FAIL load_at_max_no_ovf: got c=%0d ovf=%b, want c=3 ovf=0", c_a, ovf_a);
      n_fail++;
    end
    rst_a = 1'b1; load_a = 1'b1; d_a = 2'd2; en_a = 1'b1;
    tick();
    n_checks++;
    if (c_a !== 2'd0 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
      $display("FAIL rst_over_load: got c=%0d ovf=%b unf=%b, want c=0 ovf=0 unf=0",
               c_a, ovf_a, unf_a);
      n_fail++;
    end
    rst_a = 1'b0; load_a = 1'b0; en_a = 1'b0; up_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (c_a !== 2'd0 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
        $display("FAIL hold[%0d]: got c=%0d ovf=%b unf=%b, want c=0 ovf=0 unf=0",
                 i, c_a, ovf_a, unf_a);
        n_fail++;
      end
    end
  endtask

  task automatic test_mid_reset();
    en_a = 1'b1; up_a = 1'b1;
    tick();
    tick();
    n_checks++;
    if (c_a !== 2'd2) begin
      $display("FAIL mid_pre: got c=%0d, want 2", c_a);
      n_fail++;
    end
    rst_a = 1'b1;
    tick();
    n_checks++;
    if (c_a !== 2'd0 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
      $display("FAIL mid_rst: got c=%0d ovf=%b unf=%b, want c=0 ovf=0 unf=0", c_a, ovf_a, unf_a);
      n_fail++;
    end
    rst_a = 1'b0;
    tick();
    n_checks++;
    if (c_a !== 2'd1) begin
      $display("FAIL mid_resume1: got c=%0d, want 1", c_a);
      n_fail++;
    end
    tick();
    n_checks++;
    if (c_a !== 2'd2) begin
      $display("FAIL mid_resume2: got c=%0d, want 2", c_a);
      n_fail++;
    end
    en_a = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_wrap_up();
    test_down_wrap();
    test_back_to_back();
    test_sat_up();
    test_sat_down_clamp();
    test_priority();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
